// File: rtl/bus_timer_peripheral_pkg.sv
// Shared constants and types for the bus-mapped interval timer.
package timer_pkg;

  localparam logic [7:0] TIMER_ADDR_LO  = 8'hF0;
  localparam logic [7:0] TIMER_ADDR_MID = 8'hF1;
  localparam logic [7:0] TIMER_ADDR_HI  = 8'hF3;

  localparam int COUNT_W = 24;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

endpackage

// File: rtl/bus_timer_peripheral_if.sv
// Processor-side bus/interrupt bundle of the timer; master = processor, slave = timer.
interface bus_timer_peripheral_if #(
  parameter int COUNT_W = timer_pkg::COUNT_W
);

  logic [7:0]         BUS_DATA;
  logic               BUS_WE;
  logic               SEL_LO;
  logic               SEL_MID;
  logic               SEL_HI;
  logic               IRQ_ACK;
  logic               IRQ_RAISE;
  logic               OVERRUN;
  logic [COUNT_W-1:0] TIMER_COUNT;

  modport master (
    output BUS_DATA, BUS_WE, SEL_LO, SEL_MID, SEL_HI, IRQ_ACK,
    input  IRQ_RAISE, OVERRUN, TIMER_COUNT
  );

  modport slave (
    input  BUS_DATA, BUS_WE, SEL_LO, SEL_MID, SEL_HI, IRQ_ACK,
    output IRQ_RAISE, OVERRUN, TIMER_COUNT
  );

endinterface

// File: rtl/bus_timer_peripheral_tick_prescaler.sv
// Divides the system clock down to a one-cycle tick pulse every PRESCALE_MAX+1 enabled cycles.
module tick_prescaler #(
  parameter int PRESCALE_MAX = 99_999
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int PW = (PRESCALE_MAX > 0) ? $clog2(PRESCALE_MAX + 1) : 1;
  localparam logic [PW-1:0] PRESCALE_TOP = PW'(PRESCALE_MAX);

  logic [PW-1:0] presc_reg;

  // Disabled means held at zero, so a fresh RUN always starts a full tick period.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc_reg <= '0;
    end else if (CLR || !EN) begin
      presc_reg <= '0;
    end else if (presc_reg == PRESCALE_TOP) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  assign TICK = EN && (presc_reg == PRESCALE_TOP);

endmodule

// File: rtl/bus_timer_peripheral.sv
// Bus-mapped interval timer: byte-wise interval load, tick counter, level IRQ with overrun flag.
module bus_timer_peripheral
  import timer_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int COUNT_W     = timer_pkg::COUNT_W
) (
  input  logic                   CLK,
  input  logic                   RESET,
  bus_timer_peripheral_if.slave  bus
);

  localparam int PRESCALE_MAX = CLK_FREQ_HZ / TICK_HZ - 1;

  logic [1:0]         lane_sel;
  logic [15:0]        shadow_bytes;
  logic               commit;
  logic               tick;
  logic               expire;
  logic [COUNT_W-1:0] interval_new;

  timer_state_t       state_reg, state_next;
  logic [COUNT_W-1:0] interval_reg;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic               irq_reg, irq_next;
  logic               ovr_reg, ovr_next;

  assign lane_sel = {bus.SEL_MID, bus.SEL_LO};

  // Lower and middle bytes only stage data; nothing takes effect until the upper-byte write.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_shadow
      logic [7:0] byte_reg;
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          byte_reg <= '0;
        end else if (bus.BUS_WE && lane_sel[gi]) begin
          byte_reg <= bus.BUS_DATA;
        end
      end
      assign shadow_bytes[gi*8 +: 8] = byte_reg;
    end
  endgenerate

  assign commit       = bus.BUS_WE && bus.SEL_HI;
  assign interval_new = COUNT_W'({bus.BUS_DATA, shadow_bytes});

  tick_prescaler #(
    .PRESCALE_MAX (PRESCALE_MAX)
  ) u_prescaler (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (state_reg == RUN),
    .CLR   (commit),
    .TICK  (tick)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg    <= IDLE;
      interval_reg <= '0;
      count_reg    <= '0;
      irq_reg      <= 1'b0;
      ovr_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      irq_reg      <= irq_next;
      ovr_reg      <= ovr_next;
      if (commit) begin
        interval_reg <= interval_new;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    expire     = 1'b0;

    case (state_reg)
      IDLE: count_next = '0;
      RUN: begin
        if (tick) begin
          if (count_reg == interval_reg - COUNT_W'(1)) begin
            count_next = '0;
            expire     = 1'b1;
          end else begin
            count_next = count_reg + COUNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A commit restarts everything and overrides any expiry in the same cycle.
    if (commit) begin
      state_next = (interval_new != '0) ? RUN : IDLE;
      count_next = '0;
      expire     = 1'b0;
    end
  end

  always_comb begin
    irq_next = irq_reg;
    ovr_next = ovr_reg;
    if (commit) begin
      irq_next = 1'b0;
      ovr_next = 1'b0;
    end else if (expire) begin
      irq_next = 1'b1;
      if (irq_reg && !bus.IRQ_ACK) begin
        ovr_next = 1'b1;
      end
    end else if (bus.IRQ_ACK && irq_reg) begin
      irq_next = 1'b0;
    end
  end

  assign bus.IRQ_RAISE   = irq_reg;
  assign bus.OVERRUN     = ovr_reg;
  assign bus.TIMER_COUNT = count_reg;

endmodule

// File: tb/tb_bus_timer_peripheral.sv
// Directed bench for bus_timer_peripheral with a 10-cycle tick (CLK_FREQ_HZ=10, TICK_HZ=1).
module tb_bus_timer_peripheral;

  logic CLK;
  logic RESET;
  int   num_checks;
  int   num_errors;

  bus_timer_peripheral_if #(.COUNT_W(24)) bus ();

  bus_timer_peripheral #(
    .CLK_FREQ_HZ (10),
    .TICK_HZ     (1),
    .COUNT_W     (24)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // sel: 0=lower, 1=middle, 2=upper (commit)
  task automatic bus_write(input int sel, input logic [7:0] data);
    bus.BUS_DATA = data;
    bus.BUS_WE   = 1'b1;
    bus.SEL_LO   = (sel == 0);
    bus.SEL_MID  = (sel == 1);
    bus.SEL_HI   = (sel == 2);
    $display("write sel=%0d data=0x%02h", sel, data);
    step(1);
    bus.BUS_WE  = 1'b0;
    bus.SEL_LO  = 1'b0;
    bus.SEL_MID = 1'b0;
    bus.SEL_HI  = 1'b0;
  endtask

  // Leaves the bench at the falling edge just after the commit edge (t = 0).
  task automatic commit_interval(input logic [23:0] iv);
    bus_write(0, iv[7:0]);
    bus_write(1, iv[15:8]);
    bus_write(2, iv[23:16]);
  endtask

  task automatic ack_pulse();
    bus.IRQ_ACK = 1'b1;
    $display("irq ack");
    step(1);
    bus.IRQ_ACK = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input int cnt, input bit irq, input bit ovr);
    check_val({tag, "_count"}, 32'(bus.TIMER_COUNT), 32'(cnt));
    check_val({tag, "_irq"}, 32'(bus.IRQ_RAISE), 32'(irq));
    check_val({tag, "_ovr"}, 32'(bus.OVERRUN), 32'(ovr));
  endtask

  initial begin
    num_checks  = 0;
    num_errors  = 0;
    RESET       = 1'b1;
    bus.BUS_DATA = 8'h00;
    bus.BUS_WE   = 1'b0;
    bus.SEL_LO   = 1'b0;
    bus.SEL_MID  = 1'b0;
    bus.SEL_HI   = 1'b0;
    bus.IRQ_ACK  = 1'b0;

    step(2);
    check_outputs("reset", 0, 1'b0, 1'b0);
    RESET = 1'b0;
    step(1);

    // Interval 3: count 0,1,2 per 10 cycles, IRQ on the wrap edge.
    commit_interval(24'h000003);
    check_outputs("t1_c0", 0, 1'b0, 1'b0);
    step(9);
    check_outputs("t1_c9", 0, 1'b0, 1'b0);
    step(1);
    check_outputs("t1_c10", 1, 1'b0, 1'b0);
    step(10);
    check_outputs("t1_c20", 2, 1'b0, 1'b0);
    step(9);
    check_outputs("t1_c29", 2, 1'b0, 1'b0);
    step(1);
    check_outputs("t1_c30", 0, 1'b1, 1'b0);

    // Second expiry without an acknowledge sets OVERRUN.
    step(29);
    check_outputs("t2_c59", 2, 1'b1, 1'b0);
    step(1);
    check_outputs("t2_c60", 0, 1'b1, 1'b1);
    ack_pulse();
    check_outputs("t2_ack", 0, 1'b0, 1'b1);

    // ACK coinciding with an expiry: IRQ stays, no overrun.
    commit_interval(24'h000003);
    check_outputs("t3_c0", 0, 1'b0, 1'b0);
    step(30);
    check_outputs("t3_c30", 0, 1'b1, 1'b0);
    step(29);
    ack_pulse();
    check_outputs("t3_c60", 0, 1'b1, 1'b0);
    ack_pulse();
    check_outputs("t3_ack", 0, 1'b0, 1'b0);

    // Interval 1 expires on every tick.
    commit_interval(24'h000001);
    step(9);
    check_outputs("iv1_c9", 0, 1'b0, 1'b0);
    step(1);
    check_outputs("iv1_c10", 0, 1'b1, 1'b0);
    step(10);
    check_outputs("iv1_c20", 0, 1'b1, 1'b1);

    // Interval 0 stays idle; lower/middle writes alone do not start it.
    commit_interval(24'h000000);
    check_outputs("t4_c0", 0, 1'b0, 1'b0);
    step(40);
    check_outputs("t4_idle", 0, 1'b0, 1'b0);
    bus_write(0, 8'h05);
    bus_write(1, 8'h00);
    step(40);
    check_outputs("t4_nocommit", 0, 1'b0, 1'b0);

    // Upper select without write strobe must not restart the count.
    commit_interval(24'h000003);
    step(15);
    check_outputs("t5_c15", 1, 1'b0, 1'b0);
    bus.BUS_DATA = 8'h01;
    bus.SEL_HI   = 1'b1;
    $display("sel_hi without write strobe");
    step(1);
    bus.SEL_HI   = 1'b0;
    bus.BUS_DATA = 8'h00;
    step(4);
    check_outputs("t5_c20", 2, 1'b0, 1'b0);
    step(10);
    check_outputs("t5_c30", 0, 1'b1, 1'b0);

    // Asynchronous reset mid-count with IRQ pending.
    step(20);
    check_outputs("t6_pre", 2, 1'b1, 1'b0);
    #1 RESET = 1'b1;
    $display("async reset asserted");
    #1 check_outputs("t6_async", 0, 1'b0, 1'b0);
    step(2);
    RESET = 1'b0;
    step(30);
    check_outputs("t6_after", 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
